// File: rtl/data_io_fifo.sv
// UIO file-download port: SPI byte assembler, word FIFO and RAM write handshake.
// Optional DATA_IO_CHECKSUM_EN adds a running byte checksum output.
module data_io_fifo #(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 25,
  parameter int unsigned START_ADDR = 0,
  parameter int          DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sck,
  input  logic                  ss,
  input  logic                  sdi,
  output logic                  downloading,
  output logic [7:0]            index,
  output logic [ADDR_WIDTH:0]   size,
  output logic                  overflow,
  output logic                  wr,
  input  logic                  ack,
  output logic [ADDR_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] d
`ifdef DATA_IO_CHECKSUM_EN
  ,
  output logic [7:0]            checksum
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(START_ADDR);

  typedef enum logic {S_IDLE, S_WAIT} wst_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [2:0] sck_q;
  logic [1:0] ss_q;
  logic [1:0] sdi_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] sr_q;
  logic [7:0] cmd_q;
  logic       cmd_vld_q;

  logic       sck_rise;
  logic [7:0] byte_w;
  logic       byte_done;
  logic       payload;
  logic       start;
  logic       stop;
  logic       dbyte;

  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic                  accept;
  logic                  empty;
  logic                  full;
  entry_t                head;

  entry_t                mem_q [DEPTH];
  logic [PW:0]           wptr_q;
  logic [PW:0]           rptr_q;
  logic [ADDR_WIDTH-1:0] push_addr_q;
  logic                  ovf_q;
  logic [ADDR_WIDTH:0]   size_q;
  logic [7:0]            index_q;
  logic                  dl_q;
  logic                  end_pend_q;

  wst_e                  st_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign byte_w    = {sr_q, sdi_q[1]};
  assign byte_done = sck_rise & ~ss_q[1] & (bit_cnt_q == 3'd7);
  assign payload   = byte_done & cmd_vld_q;
  assign start     = payload & (cmd_q == 8'h53) & byte_w[0];
  assign stop      = payload & (cmd_q == 8'h53) & ~byte_w[0];
  assign dbyte     = payload & (cmd_q == 8'h54) & dl_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_q     <= '0;
      ss_q      <= '1;
      sdi_q     <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      cmd_q     <= '0;
      cmd_vld_q <= 1'b0;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      ss_q  <= {ss_q[0], ss};
      sdi_q <= {sdi_q[0], sdi};
      if (ss_q[1]) begin
        bit_cnt_q <= '0;
        cmd_vld_q <= 1'b0;
      end else if (sck_rise) begin
        sr_q      <= byte_w[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7 && !cmd_vld_q) begin
          cmd_q     <= byte_w;
          cmd_vld_q <= 1'b1;
        end
      end
    end
  end

  // 16-bit words are little-endian; end flushes a lone low byte.
  if (DATA_WIDTH == 16) begin : g_w16
    logic [7:0] lo_q;
    logic       half_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lo_q   <= '0;
        half_q <= 1'b0;
      end else if (start || stop) begin
        half_q <= 1'b0;
      end else if (dbyte) begin
        if (!half_q) lo_q <= byte_w;
        half_q <= ~half_q;
      end
    end

    assign push      = (dbyte | stop) & half_q;
    assign push_data = dbyte ? DATA_WIDTH'({byte_w, lo_q})
                             : DATA_WIDTH'({8'h00, lo_q});
  end else begin : g_w8
    assign push      = dbyte;
    assign push_data = DATA_WIDTH'(byte_w);
  end

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[PW] != rptr_q[PW]) &&
                  (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign head   = mem_q[rptr_q[PW-1:0]];
  assign pop    = (st_q == S_WAIT) & ack;
  assign accept = push & (~full | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (start) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (accept) begin
        mem_q[wptr_q[PW-1:0]] <= '{addr: push_addr_q, data: push_data};
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Address advances even for dropped words so file offsets hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_addr_q <= START;
      ovf_q       <= 1'b0;
      size_q      <= '0;
      index_q     <= '0;
    end else begin
      if (start) begin
        push_addr_q <= START;
        ovf_q       <= 1'b0;
        size_q      <= '0;
      end else begin
        if (push) push_addr_q <= push_addr_q + 1'b1;
        if (push && full && !pop) ovf_q <= 1'b1;
        if (dbyte && !(&size_q)) size_q <= size_q + 1'b1;
      end
      if (payload && cmd_q == 8'h55) index_q <= byte_w;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q       <= 1'b0;
      end_pend_q <= 1'b0;
    end else if (start) begin
      dl_q       <= 1'b1;
      end_pend_q <= 1'b0;
    end else if (stop && dl_q) begin
      end_pend_q <= 1'b1;
    end else if (end_pend_q && empty && !wr_q) begin
      dl_q       <= 1'b0;
      end_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= S_IDLE;
      wr_q <= 1'b0;
      a_q  <= START;
      d_q  <= '0;
    end else if (start) begin
      st_q <= S_IDLE;
      wr_q <= 1'b0;
      a_q  <= START;
    end else begin
      unique case (st_q)
        S_IDLE: if (!empty) begin
          a_q  <= head.addr;
          d_q  <= head.data;
          wr_q <= 1'b1;
          st_q <= S_WAIT;
        end
        S_WAIT: if (ack) begin
          wr_q <= 1'b0;
          st_q <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

`ifdef DATA_IO_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   csum_q <= '0;
    else if (start) csum_q <= '0;
    else if (dbyte) csum_q <= csum_q + byte_w;
  end

  assign checksum = csum_q;
`endif

  assign downloading = dl_q;
  assign index       = index_q;
  assign size        = size_q;
  assign overflow    = ovf_q;
  assign wr          = wr_q;
  assign a           = a_q;
  assign d           = d_q;

endmodule

// File: tb/tb_data_io_fifo.sv
// Bench for data_io_fifo: an 8-bit and a 16-bit instance on shared sck/sdi
// with separate selects, write scoreboards per instance.
module tb_data_io_fifo;

  typedef struct packed {
    logic [24:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [7:0]  din;
    logic [24:0] exp_a;
    logic [15:0] exp_d;
    logic [25:0] exp_size;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic sck, sdi, ss8, ss16;
  logic ack8, ack16;
  logic ack_en8, ack_en16;

  logic        dl8, dl16, ovf8, ovf16, wr8, wr16;
  logic [7:0]  idx8, idx16;
  logic [25:0] size8, size16;
  logic [24:0] a8, a16;
  logic [7:0]  d8;
  logic [15:0] d16;
`ifdef DATA_IO_CHECKSUM_EN
  logic [7:0]  cs8, cs16;
`endif

  int checks = 0;
  int errors = 0;
  wr_t q8[$];
  wr_t q16[$];

  always #5 clk = ~clk;

  data_io_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(25), .START_ADDR(0), .DEPTH(4))
  dut8 (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss8), .sdi(sdi),
    .downloading(dl8), .index(idx8), .size(size8), .overflow(ovf8),
    .wr(wr8), .ack(ack8), .a(a8), .d(d8)
`ifdef DATA_IO_CHECKSUM_EN
    , .checksum(cs8)
`endif
  );

  data_io_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(25), .START_ADDR(0), .DEPTH(4))
  dut16 (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss16), .sdi(sdi),
    .downloading(dl16), .index(idx16), .size(size16), .overflow(ovf16),
    .wr(wr16), .ack(ack16), .a(a16), .d(d16)
`ifdef DATA_IO_CHECKSUM_EN
    , .checksum(cs16)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sdi = b[i];
      wclk(4);
      sck = 1'b1;
      wclk(4);
      sck = 1'b0;
    end
  endtask

  task automatic begin_frame(input bit s16);
    if (s16) ss16 = 1'b0;
    else     ss8  = 1'b0;
    wclk(4);
  endtask

  task automatic end_frame();
    wclk(4);
    ss8  = 1'b1;
    ss16 = 1'b1;
    wclk(4);
  endtask

  task automatic frame2(input bit s16, input logic [7:0] c,
                        input logic [7:0] p);
    begin_frame(s16);
    send_byte(c);
    send_byte(p);
    end_frame();
  endtask

  task automatic wait_idle(input bit s16, input bit need_end,
                           input string name);
    int n = 0;
    while (n < 400) begin
      if (s16 ? (q16.size() == 0 && (!need_end || !dl16))
              : (q8.size() == 0 && (!need_end || !dl8))) break;
      wclk(1);
      n++;
    end
    chk(name, 64'(n < 400), 64'd1);
  endtask

  initial begin
    vec_t tbl[3];
    tbl[0] = '{din: 8'h11, exp_a: 25'd0, exp_d: 16'h11, exp_size: 26'd1};
    tbl[1] = '{din: 8'h22, exp_a: 25'd1, exp_d: 16'h22, exp_size: 26'd2};
    tbl[2] = '{din: 8'h33, exp_a: 25'd2, exp_d: 16'h33, exp_size: 26'd3};

    reset_n = 1'b0;
    sck = 1'b0; sdi = 1'b0; ss8 = 1'b1; ss16 = 1'b1;
    ack8 = 1'b0; ack16 = 1'b0; ack_en8 = 1'b1; ack_en16 = 1'b1;

    fork
      forever begin
        @(posedge clk);
        #1;
        ack8  = ack_en8  && wr8  && !ack8;
        ack16 = ack_en16 && wr16 && !ack16;
      end
      forever begin
        wr_t e;
        @(negedge clk);
        if (reset_n && wr8 && ack8) begin
          if (q8.size() == 0) chk("write8 unexpected", 64'({a8, 8'h0, d8}), 64'h0);
          else begin
            e = q8.pop_front();
            chk("write8", 64'({a8, 8'h0, d8}), 64'(e));
          end
        end
        if (reset_n && wr16 && ack16) begin
          if (q16.size() == 0) chk("write16 unexpected", 64'({a16, d16}), 64'h0);
          else begin
            e = q16.pop_front();
            chk("write16", 64'({a16, d16}), 64'(e));
          end
        end
      end
    join_none

    wclk(3);
    reset_n = 1'b1;
    wclk(1);
    chk("rst downloading", 64'(dl8), 64'd0);
    chk("rst index", 64'(idx8), 64'd0);
    chk("rst size", 64'(size8), 64'd0);
    chk("rst overflow", 64'(ovf8), 64'd0);
    chk("rst a", 64'(a8), 64'd0);
    chk("rst d", 64'(d8), 64'd0);
    chk("rst d16", 64'(d16), 64'd0);
    for (int i = 0; i < 20; i++) begin
      wclk(1);
      chk("rst wr idle", 64'({wr8, wr16}), 64'd0);
    end

    // DW=8 basic download
    frame2(1'b0, 8'h53, 8'h01);
    chk("start downloading", 64'(dl8), 64'd1);
    begin_frame(1'b0);
    send_byte(8'h54);
    for (int i = 0; i < 3; i++) begin
      q8.push_back('{a: tbl[i].exp_a, d: tbl[i].exp_d});
      send_byte(tbl[i].din);
      chk("size8 table", 64'(size8), 64'(tbl[i].exp_size));
    end
    end_frame();
    frame2(1'b0, 8'h53, 8'h00);
    wait_idle(1'b0, 1'b1, "drain dw8");
    chk("dw8 downloading off", 64'(dl8), 64'd0);
    chk("dw8 size", 64'(size8), 64'd3);

    // DW=16 with partial final word
    frame2(1'b1, 8'h53, 8'h01);
    q16.push_back('{a: 25'd0, d: 16'hBBAA});
    q16.push_back('{a: 25'd1, d: 16'h00CC});
    begin_frame(1'b1);
    send_byte(8'h54);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    end_frame();
    frame2(1'b1, 8'h53, 8'h00);
    wait_idle(1'b1, 1'b1, "drain dw16");
    chk("dw16 size", 64'(size16), 64'd3);
    chk("dw16 overflow", 64'(ovf16), 64'd0);

    // Overflow with ack held low
    ack_en8 = 1'b0;
    frame2(1'b0, 8'h53, 8'h01);
    begin_frame(1'b0);
    send_byte(8'h54);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    end_frame();
    chk("ovf set", 64'(ovf8), 64'd1);
    chk("ovf wr held", 64'({wr8, a8, d8}), 64'({1'b1, 25'd0, 8'h01}));
    for (int i = 0; i < 4; i++) q8.push_back('{a: 25'(i), d: 16'(i + 1)});
    ack_en8 = 1'b1;
    wait_idle(1'b0, 1'b0, "drain ovf");
    frame2(1'b0, 8'h53, 8'h00);
    wait_idle(1'b0, 1'b1, "end ovf");
    chk("ovf size", 64'(size8), 64'd6);
    chk("ovf sticky", 64'(ovf8), 64'd1);

    // Restart mid-download aborts the stalled write
    ack_en8 = 1'b0;
    frame2(1'b0, 8'h53, 8'h01);
    begin_frame(1'b0);
    send_byte(8'h54);
    send_byte(8'h77);
    send_byte(8'h88);
    end_frame();
    chk("abort wr pending", 64'(wr8), 64'd1);
    frame2(1'b0, 8'h53, 8'h01);
    chk("restart wr drop", 64'(wr8), 64'd0);
    chk("restart ovf clr", 64'(ovf8), 64'd0);
    chk("restart size clr", 64'(size8), 64'd0);
    ack_en8 = 1'b1;
    q8.push_back('{a: 25'd0, d: 16'h5A});
    frame2(1'b0, 8'h54, 8'h5A);
    chk("restart size", 64'(size8), 64'd1);
    frame2(1'b0, 8'h53, 8'h00);
    wait_idle(1'b0, 1'b1, "drain restart");

    // Index and checksum
    frame2(1'b0, 8'h55, 8'h07);
    chk("index", 64'(idx8), 64'h07);
    frame2(1'b0, 8'h53, 8'h01);
    q8.push_back('{a: 25'd0, d: 16'hFF});
    q8.push_back('{a: 25'd1, d: 16'h02});
    begin_frame(1'b0);
    send_byte(8'h54);
    send_byte(8'hFF);
    send_byte(8'h02);
    end_frame();
    frame2(1'b0, 8'h53, 8'h00);
    wait_idle(1'b0, 1'b1, "drain csum");
    chk("csum size", 64'(size8), 64'd2);
`ifdef DATA_IO_CHECKSUM_EN
    chk("checksum", 64'(cs8), 64'h01);
`endif

    // Data bytes outside a download are ignored
    frame2(1'b0, 8'h54, 8'h99);
    wclk(10);
    chk("idle bytes ignored", 64'({wr8, size8}), 64'({1'b0, 26'd2}));
    chk("queue empty", 64'(q8.size() + q16.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
